// File: rtl/ppi_pkg.sv
// ============================================================================
// Module   : ppi_pkg
// Brief    : Shared types and control-word constants for the 8255 port B logic
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppi_pkg;

    typedef enum logic [2:0] {
        ST_M0        = 3'd0,
        ST_IN_EMPTY  = 3'd1,
        ST_IN_STB    = 3'd2,
        ST_IN_FULL   = 3'd3,
        ST_OUT_EMPTY = 3'd4,
        ST_OUT_FULL  = 3'd5,
        ST_OUT_ACK   = 3'd6
    } state_e;

    localparam int         MODE_FLAG = 7;
    localparam int         B_MODE    = 2;
    localparam int         B_DIR     = 1;
    localparam logic [2:0] BSR_PC2   = 3'd2;

    function automatic state_e cfg_entry_state(input logic mode1, input logic dir_in);
        if (!mode1) return ST_M0;
        return dir_in ? ST_IN_EMPTY : ST_OUT_EMPTY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ppi_sync_edge.sv
// ============================================================================
// Module   : ppi_sync_edge
// Brief    : 2-FF synchroniser for an active-low strobe with rise/fall pulses
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Reset to the inactive (high) level so release never fakes a strobe edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/ppi_port_b_mode1_ctrl.sv
// ============================================================================
// Module   : ppi_port_b_mode1_ctrl
// Brief    : 8255 port B Mode 0 / Mode 1 strobed handshake controller
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppi_port_b_mode1_ctrl
    import ppi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    input  logic       cfg_mode1,
    input  logic       cfg_dir_in,
    input  logic       bsr_valid,
    input  logic [2:0] bsr_sel,
    input  logic       bsr_set,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    input  logic [7:0] pb_in,
    output logic [7:0] pb_out,
    output logic       pb_oe,
    input  logic       pc2_in,
    output logic [1:0] pc_lo_out,
    output logic       pc_lo_oe
);

    state_e     state_q, state_d;
    logic       mode1_q, mode1_d;
    logic       dir_q, dir_d;
    logic       inte_q, inte_d;
    logic [7:0] in_latch_q, in_latch_d;
    logic [7:0] pb_out_q, pb_out_d;
    logic       pb_oe_q, pb_oe_d;
    logic       pc1_q, pc1_d;
    logic       intr_q, intr_d;
    logic [7:0] rdata_q, rdata_d;
    logic       pc_lo_oe_q, pc_lo_oe_d;
    logic       pc2_rise;
    logic       pc2_fall;

    ppi_sync_edge u_pc2_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (pc2_in),
        .rise_o  (pc2_rise),
        .fall_o  (pc2_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_M0;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cfg_valid) begin
            state_d = cfg_entry_state(cfg_mode1, cfg_dir_in);
        end else begin
            case (state_q)
                ST_IN_EMPTY:  if (pc2_fall) state_d = ST_IN_STB;
                ST_IN_STB:    if (pc2_rise) state_d = ST_IN_FULL;
                ST_IN_FULL: begin
                    // A new strobe beats a concurrent read: the peripheral's data must not be lost
                    if (pc2_fall)    state_d = ST_IN_STB;
                    else if (cpu_rd) state_d = ST_IN_EMPTY;
                end
                ST_OUT_EMPTY: if (cpu_wr)   state_d = ST_OUT_FULL;
                ST_OUT_FULL:  if (pc2_fall) state_d = ST_OUT_ACK;
                ST_OUT_ACK:   if (pc2_rise) state_d = ST_OUT_EMPTY;
                default:      state_d = state_q;
            endcase
        end
    end

    always_comb begin
        mode1_d    = mode1_q;
        dir_d      = dir_q;
        inte_d     = inte_q;
        in_latch_d = in_latch_q;
        pb_out_d   = pb_out_q;
        pb_oe_d    = pb_oe_q;
        pc1_d      = pc1_q;
        intr_d     = intr_q;
        rdata_d    = rdata_q;
        pc_lo_oe_d = pc_lo_oe_q;
        if (cfg_valid) begin
            mode1_d    = cfg_mode1;
            dir_d      = cfg_dir_in;
            inte_d     = 1'b0;
            in_latch_d = 8'h00;
            pb_out_d   = 8'h00;
            pb_oe_d    = ~cfg_dir_in;
            pc1_d      = cfg_mode1 & ~cfg_dir_in;
            intr_d     = 1'b0;
            pc_lo_oe_d = cfg_mode1;
        end else begin
            if (bsr_valid && (bsr_sel == BSR_PC2) && mode1_q) inte_d = bsr_set;
            if (!inte_q) intr_d = 1'b0;
            if (cpu_rd) begin
                if (mode1_q && dir_q) rdata_d = in_latch_q;
                else if (dir_q)       rdata_d = pb_in;
                else                  rdata_d = pb_out_q;
            end
            case (state_q)
                ST_M0: if (cpu_wr) pb_out_d = cpu_wdata;
                ST_IN_EMPTY: begin
                    pc1_d = 1'b0;
                    if (pc2_fall) begin
                        in_latch_d = pb_in;
                        pc1_d      = 1'b1;
                    end
                end
                ST_IN_STB: if (pc2_rise) intr_d = inte_q;
                ST_IN_FULL: begin
                    if (pc2_fall) in_latch_d = pb_in;
                    if (pc2_fall || cpu_rd) intr_d = 1'b0;
                end
                ST_OUT_EMPTY: begin
                    if (cpu_wr) begin
                        pb_out_d = cpu_wdata;
                        pc1_d    = 1'b0;
                        intr_d   = 1'b0;
                    end
                end
                ST_OUT_FULL: begin
                    if (cpu_wr)   pb_out_d = cpu_wdata;
                    if (pc2_fall) pc1_d    = 1'b1;
                end
                ST_OUT_ACK: if (pc2_rise) intr_d = inte_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode1_q    <= 1'b0;
            dir_q      <= 1'b1;
            inte_q     <= 1'b0;
            in_latch_q <= 8'h00;
            pb_out_q   <= 8'h00;
            pb_oe_q    <= 1'b0;
            pc1_q      <= 1'b0;
            intr_q     <= 1'b0;
            rdata_q    <= 8'h00;
            pc_lo_oe_q <= 1'b0;
        end else begin
            mode1_q    <= mode1_d;
            dir_q      <= dir_d;
            inte_q     <= inte_d;
            in_latch_q <= in_latch_d;
            pb_out_q   <= pb_out_d;
            pb_oe_q    <= pb_oe_d;
            pc1_q      <= pc1_d;
            intr_q     <= intr_d;
            rdata_q    <= rdata_d;
            pc_lo_oe_q <= pc_lo_oe_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign pb_out    = pb_out_q;
    assign pb_oe     = pb_oe_q;
    assign pc_lo_out = {pc1_q, intr_q};
    assign pc_lo_oe  = pc_lo_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ppi_port_b_mode1_ctrl.sv
// ============================================================================
// Module   : tb_ppi_port_b_mode1_ctrl
// Brief    : Directed vector bench for the port B Mode 1 handshake controller
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppi_port_b_mode1_ctrl;
    import ppi_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_mode1;
    logic       cfg_dir_in;
    logic       bsr_valid;
    logic [2:0] bsr_sel;
    logic       bsr_set;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic [7:0] pb_in;
    logic [7:0] pb_out;
    logic       pb_oe;
    logic       pc2_in;
    logic [1:0] pc_lo_out;
    logic       pc_lo_oe;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       cv, cm, cd, bv;
        logic [2:0] bsel;
        logic       bs, rd, wr;
        logic [7:0] wd, pbi;
        logic       pc2;
        logic [7:0] e_rdata, e_pbout;
        logic       e_pboe;
        logic [1:0] e_pclo;
        logic       e_pcoe;
    } vec_t;

    vec_t vq[$];

    ppi_port_b_mode1_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_mode1  (cfg_mode1),
        .cfg_dir_in (cfg_dir_in),
        .bsr_valid  (bsr_valid),
        .bsr_sel    (bsr_sel),
        .bsr_set    (bsr_set),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .pb_in      (pb_in),
        .pb_out     (pb_out),
        .pb_oe      (pb_oe),
        .pc2_in     (pc2_in),
        .pc_lo_out  (pc_lo_out),
        .pc_lo_oe   (pc_lo_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic cv, cm, cd, bv, input logic [2:0] bsel,
                                input logic bs, rd, wr, input logic [7:0] wd, pbi,
                                input logic pc2, input logic [7:0] er, ep,
                                input logic eoe, input logic [1:0] epc, input logic epcoe);
        vec_t v;
        v.cv = cv; v.cm = cm; v.cd = cd; v.bv = bv; v.bsel = bsel; v.bs = bs;
        v.rd = rd; v.wr = wr; v.wd = wd; v.pbi = pbi; v.pc2 = pc2;
        v.e_rdata = er; v.e_pbout = ep; v.e_pboe = eoe; v.e_pclo = epc; v.e_pcoe = epcoe;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] er, input logic [7:0] ep,
                         input logic eoe, input logic [1:0] epc, input logic epcoe);
        tests_run++;
        if (cpu_rdata !== er || pb_out !== ep || pb_oe !== eoe ||
            pc_lo_out !== epc || pc_lo_oe !== epcoe) begin
            tests_failed++;
            $display("FAIL %s: got rdata=%h pb_out=%h pb_oe=%b pc_lo=%b pc_lo_oe=%b, want rdata=%h pb_out=%h pb_oe=%b pc_lo=%b pc_lo_oe=%b",
                     name, cpu_rdata, pb_out, pb_oe, pc_lo_out, pc_lo_oe, er, ep, eoe, epc, epcoe);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cfg_valid = 0; bsr_valid = 0; cpu_rd = 0; cpu_wr = 0;
    endtask

    initial begin
        rst_n = 0; cfg_mode1 = 0; cfg_dir_in = 0; bsr_sel = 0; bsr_set = 0;
        cpu_wdata = 0; pb_in = 0; pc2_in = 1;
        idle();

        //          cv cm cd bv bsel     bs rd wr wd     pbi    pc2 | rdata  pb_out oe pclo  pcoe
        vq.push_back(mk(1, 1, 1, 0, 3'd0,    0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 2'b00, 1));
        vq.push_back(mk(0, 0, 0, 1, BSR_PC2, 1, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 2'b00, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'hA5, 0, 8'h00, 8'h00, 0, 2'b00, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'hA5, 0, 8'h00, 8'h00, 0, 2'b00, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'hA5, 0, 8'h00, 8'h00, 0, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'hA5, 0, 8'h00, 8'h00, 0, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'hA5, 1, 8'h00, 8'h00, 0, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'hA5, 1, 8'h00, 8'h00, 0, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'hA5, 1, 8'h00, 8'h00, 0, 2'b11, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 1, 0, 8'h00, 8'hA5, 1, 8'hA5, 8'h00, 0, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'hA5, 1, 8'hA5, 8'h00, 0, 2'b00, 1));
        vq.push_back(mk(1, 1, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 8'h00, 1, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 1, BSR_PC2, 1, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 8'h00, 1, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 1, 3'd1,    0, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 8'h00, 1, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 1, 8'h3C, 8'h00, 1, 8'hA5, 8'h3C, 1, 2'b00, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 8'h3C, 1, 2'b00, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 8'h3C, 1, 2'b00, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 8'h3C, 1, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 8'h3C, 1, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 8'h3C, 1, 2'b10, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 8'h3C, 1, 2'b11, 1));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 1, 8'h77, 8'h00, 1, 8'hA5, 8'h77, 1, 2'b00, 1));
        vq.push_back(mk(1, 0, 0, 0, 3'd0,    0, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 8'h00, 1, 2'b00, 0));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 0, 1, 8'h99, 8'h00, 1, 8'hA5, 8'h99, 1, 2'b00, 0));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 1, 0, 8'h00, 8'h00, 1, 8'h99, 8'h99, 1, 2'b00, 0));
        vq.push_back(mk(1, 0, 1, 0, 3'd0,    0, 0, 0, 8'h00, 8'h00, 1, 8'h99, 8'h00, 0, 2'b00, 0));
        vq.push_back(mk(0, 0, 0, 0, 3'd0,    0, 1, 0, 8'h00, 8'h42, 1, 8'h42, 8'h00, 0, 2'b00, 0));

        #3;
        check("reset_state", 8'h00, 8'h00, 0, 2'b00, 0);
        step();
        rst_n = 1;
        step();

        for (int i = 0; i < vq.size(); i++) begin
            cfg_valid = vq[i].cv; cfg_mode1 = vq[i].cm; cfg_dir_in = vq[i].cd;
            bsr_valid = vq[i].bv; bsr_sel = vq[i].bsel; bsr_set = vq[i].bs;
            cpu_rd = vq[i].rd; cpu_wr = vq[i].wr; cpu_wdata = vq[i].wd;
            pb_in = vq[i].pbi; pc2_in = vq[i].pc2;
            step();
            check($sformatf("vec%0d", i), vq[i].e_rdata, vq[i].e_pbout, vq[i].e_pboe,
                  vq[i].e_pclo, vq[i].e_pcoe);
        end
        idle();

        // Full input cycle with interrupts disabled, then a late BSR enable
        cfg_valid = 1; cfg_mode1 = 1; cfg_dir_in = 1; step(); idle();
        check("cfg_in_inte0", 8'h42, 8'h00, 0, 2'b00, 1);
        pb_in = 8'h11; pc2_in = 0;
        repeat (3) step();
        check("inte0_ibf", 8'h42, 8'h00, 0, 2'b10, 1);
        step();
        pc2_in = 1;
        repeat (3) step();
        check("inte0_no_intr", 8'h42, 8'h00, 0, 2'b10, 1);
        bsr_valid = 1; bsr_sel = BSR_PC2; bsr_set = 1; step(); idle();
        step();
        check("bsr_no_retro", 8'h42, 8'h00, 0, 2'b10, 1);

        // Read coincident with the next strobe fall in IN_FULL
        pb_in = 8'h5A; pc2_in = 0;
        repeat (2) step();
        cpu_rd = 1; step(); idle();
        check("rd_stb_collide", 8'h11, 8'h00, 0, 2'b10, 1);
        step();
        check("rd_stb_ibf_hold", 8'h11, 8'h00, 0, 2'b10, 1);
        pc2_in = 1;
        repeat (3) step();
        check("intr_after_bsr", 8'h11, 8'h00, 0, 2'b11, 1);
        cpu_rd = 1; step(); idle();
        check("read_5a", 8'h5A, 8'h00, 0, 2'b10, 1);
        step();
        check("ibf_clear", 8'h5A, 8'h00, 0, 2'b00, 1);

        // Asynchronous reset while in IN_STB
        pb_in = 8'h66; pc2_in = 0;
        repeat (3) step();
        check("in_stb_again", 8'h5A, 8'h00, 0, 2'b10, 1);
        #2 rst_n = 0;
        #1 check("reset_mid_hs", 8'h00, 8'h00, 0, 2'b00, 0);
        pc2_in = 1;
        step();
        rst_n = 1;
        cpu_wr = 1; cpu_wdata = 8'hAB; step(); idle();
        check("m0_after_reset", 8'h00, 8'hAB, 0, 2'b00, 0);

        // Write coincident with ACK fall in OUT_FULL
        cfg_valid = 1; cfg_mode1 = 1; cfg_dir_in = 0; step(); idle();
        check("cfg_out", 8'h00, 8'h00, 1, 2'b10, 1);
        bsr_valid = 1; bsr_sel = BSR_PC2; bsr_set = 1; step(); idle();
        cpu_wr = 1; cpu_wdata = 8'h11; step(); idle();
        check("out_wr11", 8'h00, 8'h11, 1, 2'b00, 1);
        pc2_in = 0;
        repeat (2) step();
        cpu_wr = 1; cpu_wdata = 8'h22; step(); idle();
        check("wr_ack_collide", 8'h00, 8'h22, 1, 2'b10, 1);
        pc2_in = 1;
        repeat (3) step();
        check("ack_rise_intr", 8'h00, 8'h22, 1, 2'b11, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
